// File: rtl/run_launcher_pkg.sv
// Shared types and default widths for the run launcher.
// Optional watchdog feature is controlled by the RUN_WATCHDOG_EN macro.
package run_launcher_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_CNT_W      = 15;
    localparam int DEF_QDEPTH     = 4;
    localparam int DEF_MAX_CYCLES = 20000;

    localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        REPORT
    } run_state_t;

endpackage

// File: rtl/run_launcher_addr_fifo.sv
// Start-address queue for the run launcher.
// Ready comes from the registered occupancy, so a push is refused at full even when a pop happens that cycle.
module run_addr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         ready,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (count == '0);
    assign push_ok  = push && ready;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= (count_next != (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/run_launcher.sv
// Queues program start addresses, launches one processor run at a time and reports {addr, cycles}.
// Define RUN_WATCHDOG_EN to abort runs that exceed MAX_CYCLES.
module run_launcher
    import run_launcher_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int QDEPTH = DEF_QDEPTH
`ifdef RUN_WATCHDOG_EN
    ,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
`endif
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    output logic              start_o,
    output logic [ADDR_W-1:0] start_addr_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic [CNT_W-1:0]  res_cycles_o,
    output logic              res_timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    run_state_t        state;
    run_state_t        state_next;
    logic              pop;
    logic              empty;
    logic [ADDR_W-1:0] pop_data;
    logic [ADDR_W-1:0] launch_addr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_inc;
    logic              wd_hit;
    logic [ADDR_W-1:0] res_addr_q;
    logic [CNT_W-1:0]  res_cycles_q;
    logic              res_timeout_q;

    run_addr_fifo #(
        .W     (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .push      (req_valid_i),
        .push_data (req_addr_i),
        .ready     (req_ready_o),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty)
    );

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

`ifdef RUN_WATCHDOG_EN
    // A done in the same cycle as the limit wins over the timeout.
    assign wd_hit = (int'(count_inc) == MAX_CYCLES) && !done_i;
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (done_i || wd_hit) state_next = REPORT;
            end
            REPORT: begin
                if (res_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            launch_addr_q <= '0;
            count_q       <= '0;
            res_addr_q    <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) launch_addr_q <= pop_data;
            if (state == LAUNCH) count_q <= '0;
            if (state == WAIT) begin
                count_q <= count_inc;
                if (state_next == REPORT) begin
                    res_addr_q    <= launch_addr_q;
                    res_cycles_q  <= count_inc;
                    res_timeout_q <= wd_hit;
                end
            end
        end
    end

    assign start_o       = (state == LAUNCH);
    assign start_addr_o  = start_o ? launch_addr_q : '0;
    assign busy_o        = (state == LAUNCH) || (state == WAIT);
    assign res_valid_o   = (state == REPORT);
    assign res_addr_o    = res_addr_q;
    assign res_cycles_o  = res_cycles_q;
    assign res_timeout_o = res_timeout_q;

endmodule
